pong_score_overlay: RTL and testbench

- Holds both players' scores, converts each score to two seven-segment digits, and generates the score and "End" pixel overlays for the VGA renderer.
- Sits between the ball/collision logic, which supplies the point-scored strobes, and the rgb mux, which consumes the pixel-hit flags.
- Runs entirely in the pixel-clock domain.

---
 rtl/pong_score_overlay.sv | 167 ++++++++++++++++
 tb/tb_pong_score_overlay.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pong_score_overlay.sv
// Pong score keeper: edge-detected point strobes, saturating scores, seven-segment
// digit decode and registered pixel-hit flags for the score digits and "End" banner.
module pong_score_overlay #(
    parameter logic [9:0] SCORE_Y   = 10'd25,
    parameter logic [9:0] P1_TENS_X = 10'd242,
    parameter logic [9:0] P1_ONES_X = 10'd276,
    parameter logic [9:0] P2_TENS_X = 10'd340,
    parameter logic [9:0] P2_ONES_X = 10'd374,
    parameter logic [9:0] END_X     = 10'd276,
    parameter logic [9:0] END_Y     = 10'd220
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit_p1,
    input  logic       hit_p2,
    input  logic       clear,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       show_score,
    input  logic       show_end,
    output logic [4:0] score_p1,
    output logic [4:0] score_p2,
    output logic [6:0] seg_p1_tens,
    output logic [6:0] seg_p1_ones,
    output logic [6:0] seg_p2_tens,
    output logic [6:0] seg_p2_ones,
    output logic       score_pixel,
    output logic       end_pixel
);

    localparam logic [9:0] GLYPH_PITCH = 10'd34;
    localparam logic [4:0] SCORE_MAX   = 5'd31;

    logic [4:0] score_p1_reg, score_p2_reg;
    logic       hit_p1_reg, hit_p2_reg;
    logic       score_pixel_reg, end_pixel_reg;

    logic       rise_p1, rise_p2;
    logic [1:0] tens_p1, tens_p2;
    logic [3:0] ones_p1, ones_p2;
    logic [6:0] digit_seg [4];
    logic [9:0] digit_x   [4];
    logic [6:0] end_seg   [3];
    logic [3:0] digit_hit;
    logic [2:0] end_hit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Scores never exceed 31, so a compare chain replaces a divider.
    function automatic logic [1:0] tens_of(input logic [4:0] s);
        logic [1:0] t;
        if (s >= 5'd30)      t = 2'd3;
        else if (s >= 5'd20) t = 2'd2;
        else if (s >= 5'd10) t = 2'd1;
        else                 t = 2'd0;
        return t;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] s, input logic [1:0] t);
        logic [4:0] r;
        r = s - ({3'd0, t} * 5'd10);
        return r[3:0];
    endfunction

    // 24x44 cell; bars are 4 pixels thick, with b/c and e/f overlapping on the g rows.
    function automatic logic glyph_hit(input logic [9:0] px, input logic [9:0] py,
                                       input logic [9:0] x0, input logic [9:0] y0,
                                       input logic [6:0] pat);
        logic [9:0] dx, dy;
        logic       in_cell;
        dx      = px - x0;
        dy      = py - y0;
        in_cell = (px >= x0) && (py >= y0) && (dx < 10'd24) && (dy < 10'd44);
        return in_cell && (
               (pat[0] && (dy <= 10'd3)) ||
               (pat[1] && (dx >= 10'd20) && (dy <= 10'd23)) ||
               (pat[2] && (dx >= 10'd20) && (dy >= 10'd20)) ||
               (pat[3] && (dy >= 10'd40)) ||
               (pat[4] && (dx <= 10'd3) && (dy >= 10'd20)) ||
               (pat[5] && (dx <= 10'd3) && (dy <= 10'd23)) ||
               (pat[6] && (dy >= 10'd20) && (dy <= 10'd23)));
    endfunction

    assign rise_p1 = hit_p1 && !hit_p1_reg;
    assign rise_p2 = hit_p2 && !hit_p2_reg;

    assign tens_p1 = tens_of(score_p1_reg);
    assign tens_p2 = tens_of(score_p2_reg);
    assign ones_p1 = ones_of(score_p1_reg, tens_p1);
    assign ones_p2 = ones_of(score_p2_reg, tens_p2);

    assign seg_p1_tens = seg_decode({2'd0, tens_p1});
    assign seg_p1_ones = seg_decode(ones_p1);
    assign seg_p2_tens = seg_decode({2'd0, tens_p2});
    assign seg_p2_ones = seg_decode(ones_p2);

    assign digit_seg[0] = seg_p1_tens;
    assign digit_seg[1] = seg_p1_ones;
    assign digit_seg[2] = seg_p2_tens;
    assign digit_seg[3] = seg_p2_ones;
    assign digit_x[0]   = P1_TENS_X;
    assign digit_x[1]   = P1_ONES_X;
    assign digit_x[2]   = P2_TENS_X;
    assign digit_x[3]   = P2_ONES_X;

    assign end_seg[0] = 7'h79;
    assign end_seg[1] = 7'h54;
    assign end_seg[2] = 7'h5E;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_hit[gi] = glyph_hit(x, y, digit_x[gi], SCORE_Y, digit_seg[gi]);
        end
        for (gi = 0; gi < 3; gi++) begin : g_end
            localparam logic [9:0] GX = END_X + GLYPH_PITCH * 10'(gi);
            assign end_hit[gi] = glyph_hit(x, y, GX, END_Y, end_seg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            score_p1_reg    <= 5'd0;
            score_p2_reg    <= 5'd0;
            hit_p1_reg      <= 1'b0;
            hit_p2_reg      <= 1'b0;
            score_pixel_reg <= 1'b0;
            end_pixel_reg   <= 1'b0;
        end else begin
            hit_p1_reg <= hit_p1;
            hit_p2_reg <= hit_p2;
            if (clear) begin
                score_p1_reg <= 5'd0;
                score_p2_reg <= 5'd0;
            end else begin
                if (rise_p1 && (score_p1_reg != SCORE_MAX))
                    score_p1_reg <= score_p1_reg + 5'd1;
                if (rise_p2 && (score_p2_reg != SCORE_MAX))
                    score_p2_reg <= score_p2_reg + 5'd1;
            end
            score_pixel_reg <= show_score && (|digit_hit);
            end_pixel_reg   <= show_end && (|end_hit);
        end
    end

    assign score_p1    = score_p1_reg;
    assign score_p2    = score_p2_reg;
    assign score_pixel = score_pixel_reg;
    assign end_pixel   = end_pixel_reg;

endmodule

// File: tb/tb_pong_score_overlay.sv
// Randomized scoreboard bench for pong_score_overlay against an arithmetic reference model.
module tb_pong_score_overlay;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hit_p1 = 1'b0, hit_p2 = 1'b0, clear = 1'b0;
    logic [9:0] x = 10'd0, y = 10'd0;
    logic       show_score = 1'b0, show_end = 1'b0;
    logic [4:0] score_p1, score_p2;
    logic [6:0] seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones;
    logic       score_pixel, end_pixel;

    pong_score_overlay dut (
        .clk(clk), .reset(reset), .hit_p1(hit_p1), .hit_p2(hit_p2), .clear(clear),
        .x(x), .y(y), .show_score(show_score), .show_end(show_end),
        .score_p1(score_p1), .score_p2(score_p2),
        .seg_p1_tens(seg_p1_tens), .seg_p1_ones(seg_p1_ones),
        .seg_p2_tens(seg_p2_tens), .seg_p2_ones(seg_p2_ones),
        .score_pixel(score_pixel), .end_pixel(end_pixel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] s1, s2;
        logic [6:0] t1, o1, t2, o2;
        logic       sp, ep;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int rx0 [7] = '{0, 20, 20, 0, 0, 0, 0};
    int rx1 [7] = '{23, 23, 23, 23, 3, 3, 23};
    int ry0 [7] = '{0, 0, 20, 40, 20, 0, 20};
    int ry1 [7] = '{3, 23, 43, 43, 43, 23, 23};

    int m_s1 = 0, m_s2 = 0;
    bit m_h1 = 0, m_h2 = 0;

    function automatic bit on_glyph(int px, int py, int x0, int y0, logic [6:0] pat);
        int dx = px - x0;
        int dy = py - y0;
        for (int s = 0; s < 7; s++)
            if (pat[s] && dx >= rx0[s] && dx <= rx1[s] && dy >= ry0[s] && dy <= ry1[s])
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit score_on(int px, int py, int s1, int s2);
        return on_glyph(px, py, 242, 25, seg_tab[s1 / 10]) ||
               on_glyph(px, py, 276, 25, seg_tab[s1 % 10]) ||
               on_glyph(px, py, 340, 25, seg_tab[s2 / 10]) ||
               on_glyph(px, py, 374, 25, seg_tab[s2 % 10]);
    endfunction

    function automatic bit end_on(int px, int py);
        return on_glyph(px, py, 276, 220, 7'h79) ||
               on_glyph(px, py, 310, 220, 7'h54) ||
               on_glyph(px, py, 344, 220, 7'h5E);
    endfunction

    task automatic step(input bit r, input bit h1, input bit h2, input bit clr,
                        input int xx, input int yy, input bit ss, input bit se);
        exp_t e;
        int   n1, n2;
        @(negedge clk);
        reset = r; hit_p1 = h1; hit_p2 = h2; clear = clr;
        x = 10'(xx); y = 10'(yy); show_score = ss; show_end = se;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_h1 = 0; m_h2 = 0;
            e.sp = 1'b0; e.ep = 1'b0;
        end else begin
            e.sp = ss && score_on(xx, yy, m_s1, m_s2);
            e.ep = se && end_on(xx, yy);
            n1 = (h1 && !m_h1) ? m_s1 + 1 : m_s1;
            n2 = (h2 && !m_h2) ? m_s2 + 1 : m_s2;
            if (n1 > 31) n1 = 31;
            if (n2 > 31) n2 = 31;
            if (clr) begin n1 = 0; n2 = 0; end
            m_s1 = n1; m_s2 = n2; m_h1 = h1; m_h2 = h2;
        end
        e.s1 = 5'(m_s1); e.s2 = 5'(m_s2);
        e.t1 = seg_tab[m_s1 / 10]; e.o1 = seg_tab[m_s1 % 10];
        e.t2 = seg_tab[m_s2 / 10]; e.o2 = seg_tab[m_s2 % 10];
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int xx, input int yy, input bit ss, input bit se);
        step(1, 0, 0, 0, xx, yy, ss, se);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
        end
    endtask

    // Monitor: every registered result is compared one step after its inputs were applied.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("score_p1", {3'd0, score_p1}, {3'd0, e.s1});
            check("score_p2", {3'd0, score_p2}, {3'd0, e.s2});
            check("seg_p1_tens", {1'b0, seg_p1_tens}, {1'b0, e.t1});
            check("seg_p1_ones", {1'b0, seg_p1_ones}, {1'b0, e.o1});
            check("seg_p2_tens", {1'b0, seg_p2_tens}, {1'b0, e.t2});
            check("seg_p2_ones", {1'b0, seg_p2_ones}, {1'b0, e.o2});
            check("score_pixel", {7'd0, score_pixel}, {7'd0, e.sp});
            check("end_pixel", {7'd0, end_pixel}, {7'd0, e.ep});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 32; i++) begin
            step(1, 0, 1, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0, 0, 0);
        end

        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0, 0, 0);
        end
        pix(242, 25, 1, 0);
        pix(262, 25, 1, 0);
        pix(276, 25, 1, 0);
        pix(262, 25, 0, 0);
        pix(300, 100, 1, 0);
        pix(276, 221, 0, 1);
        pix(310, 221, 0, 1);
        pix(310, 241, 0, 1);
        pix(344, 230, 0, 1);
        pix(364, 230, 0, 1);
        pix(276, 221, 0, 0);
        pix(299, 263, 0, 1);
        pix(300, 263, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            int  xx, yy;
            bit  r;
            r  = ($urandom_range(0, 299) != 0);
            xx = $urandom_range(236, 404);
            yy = ($urandom_range(0, 1) != 0) ? $urandom_range(20, 74) : $urandom_range(214, 268);
            step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0, xx, yy,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected results never compared", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
